alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared 32-bit `ALU` datapath. Two requesters, such as the main execute stage and the address/branch unit, present operation requests over valid/ready handshakes. The block grants one request at a time and latches its operands into the `ALU` input register. It then captures the result and flags into a one-entry output buffer, which is released under a valid/ready handshake and tagged with the requester ID.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared 32-bit ALU: grants one request
// at a time, executes it, and holds the tagged result until the consumer takes it.
module alu_arbiter #(
  parameter int SIZE = 32,
  parameter int C    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_in1,
  input  logic [SIZE-1:0] req0_in2,
  input  logic [C:0]      req0_shamt,
  input  logic [C-1:0]    req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_in1,
  input  logic [SIZE-1:0] req1_in2,
  input  logic [C:0]      req1_shamt,
  input  logic [C-1:0]    req1_ctrl,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_out,
  output logic [2:0]      res_flag,
  output logic            res_id
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e          state_q, state_d;
  logic            last_id_q, last_id_d;
  logic [SIZE-1:0] op_in1_q, op_in1_d;
  logic [SIZE-1:0] op_in2_q, op_in2_d;
  logic [C:0]      op_shamt_q, op_shamt_d;
  logic [C-1:0]    op_ctrl_q, op_ctrl_d;
  logic            op_id_q, op_id_d;
  logic            res_valid_q, res_valid_d;
  logic [SIZE-1:0] res_out_q, res_out_d;
  logic [2:0]      res_flag_q, res_flag_d;
  logic            res_id_q, res_id_d;

  logic            grant0, grant1;
  logic [SIZE:0]   sum_w;
  logic [SIZE-1:0] shamt_w;
  logic [SIZE-1:0] alu_out;
  logic            alu_carry;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_id_q);
    grant1     = req1_valid && (!req0_valid || !last_id_q);
    req0_ready = (state_q == IDLE) && !rst && grant0;
    req1_ready = (state_q == IDLE) && !rst && grant1;
  end

  // The variable form uses all of in2, so amounts of 32 or more shift everything out.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    sum_w     = {1'b0, op_in1_q} + {1'b0, op_in2_q};
    shamt_w   = op_ctrl_q[C-1] ? op_in2_q : SIZE'(op_shamt_q);
    alu_out   = '0;
    alu_carry = 1'b0;
    case (op_ctrl_q[2:0])
      3'd0: begin
        alu_out   = sum_w[SIZE-1:0];
        alu_carry = sum_w[SIZE];
      end
      3'd1:    alu_out = -op_in2_q;
      3'd2:    alu_out = op_in1_q - op_in2_q;
      3'd3:    alu_out = op_in1_q & op_in2_q;
      3'd4:    alu_out = op_in1_q ^ op_in2_q;
      3'd5:    alu_out = op_in1_q << shamt_w;
      3'd6:    alu_out = op_in1_q >> shamt_w;
      default: alu_out = $unsigned($signed(op_in1_q) >>> shamt_w);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    op_in1_d    = op_in1_q;
    op_in2_d    = op_in2_q;
    op_shamt_d  = op_shamt_q;
    op_ctrl_d   = op_ctrl_q;
    op_id_d     = op_id_q;
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_flag_d  = res_flag_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          op_in1_d   = req1_ready ? req1_in1   : req0_in1;
          op_in2_d   = req1_ready ? req1_in2   : req0_in2;
          op_shamt_d = req1_ready ? req1_shamt : req0_shamt;
          op_ctrl_d  = req1_ready ? req1_ctrl  : req0_ctrl;
          op_id_d    = req1_ready;
          last_id_d  = req1_ready;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_valid_d = 1'b1;
        res_out_d   = alu_out;
        res_flag_d  = {alu_carry, op_in1_q[SIZE-1], (op_in1_q == '0)};
        res_id_d    = op_id_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every flop samples the pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      op_in1_q    <= '0;
      op_in2_q    <= '0;
      op_shamt_q  <= '0;
      op_ctrl_q   <= '0;
      op_id_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_flag_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      op_in1_q    <= op_in1_d;
      op_in2_q    <= op_in2_d;
      op_shamt_q  <= op_shamt_d;
      op_ctrl_q   <= op_ctrl_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_flag_q  <= res_flag_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_flag  = res_flag_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed results at accept,
// an independent monitor pops and compares each result as it is presented.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_in1, req0_in2;
  logic [4:0]  req0_shamt;
  logic [3:0]  req0_ctrl;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_in1, req1_in2;
  logic [4:0]  req1_shamt;
  logic [3:0]  req1_ctrl;
  logic        res_valid, res_ready;
  logic [31:0] res_out;
  logic [2:0]  res_flag;
  logic        res_id;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .res_flag(res_flag), .res_id(res_id)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic [2:0]  flag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] ct);
    if (id) begin
      req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_shamt = sh; req1_ctrl = ct;
    end else begin
      req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_shamt = sh; req0_ctrl = ct;
    end
  endtask

  // Waits (bounded) for the requester's ready, records the expected result, drops valid after the accept edge.
  task automatic await_accept(input bit id, input bit push, input logic [31:0] eo,
                              input logic [2:0] ef, output int waited);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_req%0d: got no ready in 20 cycles expected ready", id);
    end else begin
      check("other_ready_low", 32'(id ? req0_ready : req1_ready), 32'd0);
      if (push) sb_q.push_back('{id: id, out: eo, flag: ef});
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] ct,
                        input logic [31:0] eo, input logic [2:0] ef);
    int unused_wait;
    drive_req(id, a, b, sh, ct);
    await_accept(id, 1'b1, eo, ef, unused_wait);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || res_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!res_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id=%0d out=0x%08h expected no result", res_id, res_out);
        end else begin
          e = sb_q.pop_front();
          check("res_out", res_out, e.out);
          check("res_flag", 32'(res_flag), 32'(e.flag));
          check("res_id", 32'(res_id), 32'(e.id));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_shamt = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_shamt = '0; req1_ctrl = '0;

    // Reset with req0 already requesting an add that carries out.
    drive_req(1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_out", res_out, 32'd0);
      check("rst_res_flag", 32'(res_flag), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_req0_ready", 32'(req0_ready), 32'd1);
    check("first_req1_ready", 32'(req1_ready), 32'd0);
    sb_q.push_back('{id: 1'b0, out: 32'h0000_0000, flag: 3'b110});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("exec_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_res_valid", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    check("consumed_res_valid", 32'(res_valid), 32'd0);

    // Tie after reset: req0 first, then req1; a second tie grants req0 again.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 4'd4);
    drive_req(1'b1, 32'hFFFF_0000, 32'h1234_5678, 5'd0, 4'd3);
    await_accept(1'b0, 1'b1, 32'h0FF0_0FF0, 3'b010, w);
    await_accept(1'b1, 1'b1, 32'h1234_0000, 3'b010, w);
    drive_req(1'b0, 32'd5, 32'd7, 5'd0, 4'd0);
    drive_req(1'b1, 32'd0, 32'd1, 5'd0, 4'd2);
    await_accept(1'b0, 1'b1, 32'd12, 3'b000, w);
    await_accept(1'b1, 1'b1, 32'hFFFF_FFFF, 3'b001, w);
    wait_drain();

    // Backpressure: result held 5 cycles while req1 waits.
    res_ready = 1'b0;
    drive_req(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd1);
    await_accept(1'b0, 1'b1, 32'hFFFF_FFFF, 3'b010, w);
    drive_req(1'b1, 32'h1, 32'h0, 5'd31, 4'b0101);
    begin
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("bp_result_arrived", 32'(res_valid), 32'd1);
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_out", res_out, 32'hFFFF_FFFF);
      check("bp_res_flag", 32'(res_flag), 32'b010);
      check("bp_res_id", 32'(res_id), 32'd0);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req1_ready", 32'(req1_ready), 32'd0);
    await_accept(1'b1, 1'b1, 32'h8000_0000, 3'b000, w);
    check("bp_accept_delay", 32'(w), 32'd0);

    // Shifts, shift bounds, wrap-around and the remaining ops.
    run_op(1'b0, 32'h8000_0000, 32'd4,  5'd0,  4'b1111, 32'hF800_0000, 3'b010);
    run_op(1'b1, 32'hDEAD_BEEF, 32'd40, 5'd0,  4'b1110, 32'h0000_0000, 3'b010);
    run_op(1'b0, 32'h8000_0001, 32'd33, 5'd0,  4'b1111, 32'hFFFF_FFFF, 3'b010);
    run_op(1'b1, 32'h0000_00F0, 32'd1,  5'd4,  4'b0110, 32'h0000_000F, 3'b000);
    run_op(1'b0, 32'd3,         32'd2,  5'd9,  4'b1101, 32'h0000_000C, 3'b000);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd0, 4'd0, 32'h0000_0000, 3'b110);
    run_op(1'b0, 32'd10,        32'd3,  5'd0,  4'd2,    32'h0000_0007, 3'b000);
    wait_drain();

    // Reset during EXEC: the op is discarded and last_id returns to 1.
    drive_req(1'b0, 32'd2, 32'd2, 5'd0, 4'd0);
    await_accept(1'b0, 1'b0, 32'd0, 3'b000, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 32'd1, 32'd3, 5'd0, 4'd4);
    drive_req(1'b1, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd0, 4'd3);
    await_accept(1'b0, 1'b1, 32'd2, 3'b000, w);
    await_accept(1'b1, 1'b1, 32'h0000_00FF, 3'b010, w);
    wait_drain();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
